// File: rtl/oam_pkg.sv
// oam_pkg: shared OAM entry layout, scan sizing and evaluator state encoding
package oam_pkg;
  localparam int NUM_ENTRIES = 64;
  localparam int MAX_SPRITES = 8;
  typedef struct packed {
    logic [7:0] attr;
    logic [7:0] tile;
    logic [7:0] x;
    logic [7:0] y;
  } oam_entry_t;
  typedef enum logic [1:0] {IDLE, SCAN, FINISH} state_t;
endpackage

// File: rtl/sprite_line_hit.sv
// sprite_line_hit: combinational test of whether a sprite's rows cover the scanline
module sprite_line_hit (
  input  logic [7:0] y,
  input  logic [7:0] line,
  input  logic       tall,
  output logic       hit
);
  logic [8:0] diff;
  // 9-bit difference: bit 8 is the borrow, so a line above the sprite top never wraps into a hit
  always_comb begin
    diff = {1'b0, line} - {1'b0, y};
    hit = !diff[8] && diff < (tall ? 9'd16 : 9'd8);
  end
endmodule

// File: rtl/oam_sprite_evaluator.sv
// oam_sprite_evaluator: scans OAM for one scanline and streams hits into line sprite slots
module oam_sprite_evaluator #(
  parameter int NUM_ENTRIES = oam_pkg::NUM_ENTRIES,
  parameter int MAX_SPRITES = oam_pkg::MAX_SPRITES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  line,
  input  logic        tall_sprites,
  output logic [5:0]  oam_read_addr,
  input  logic [31:0] oam_read_data,
  output logic        slot_valid,
  output logic [2:0]  slot_index,
  output logic [31:0] slot_data,
  output logic        busy,
  output logic        done,
  output logic [3:0]  sprite_count,
  output logic        overflow
);
  import oam_pkg::*;
  localparam int CW = $clog2(NUM_ENTRIES + 1);
  state_t state, state_next;
  oam_entry_t entry;
  logic [CW-1:0] rd_cnt;
  logic [7:0] line_q;
  logic tall_q, eval_v, hit, reading, last_eval, store_hit, over_hit;
  assign entry = oam_read_data;
  sprite_line_hit u_hit (.y(entry.y), .line(line_q), .tall(tall_q), .hit(hit));
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_next;
  // next state and status outputs; reads are issued while the counter is below NUM_ENTRIES
  always_comb begin
    reading = state == SCAN && rd_cnt < CW'(NUM_ENTRIES);
    last_eval = eval_v && rd_cnt == CW'(NUM_ENTRIES);
    store_hit = state == SCAN && eval_v && hit && sprite_count < 4'(MAX_SPRITES);
    over_hit = state == SCAN && eval_v && hit && sprite_count == 4'(MAX_SPRITES);
    state_next = state == IDLE ? (start ? SCAN : IDLE) :
                 state == SCAN ? ((last_eval || over_hit) ? FINISH : SCAN) : IDLE;
    busy = state == SCAN;
    done = state == FINISH;
    oam_read_addr = reading ? 6'(rd_cnt) : 6'd0;
  end
  // datapath: eval_v marks the cycle the OAM data for the previous address is valid
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rd_cnt <= '0;
      eval_v <= 1'b0;
      line_q <= '0;
      tall_q <= 1'b0;
      slot_valid <= 1'b0;
      slot_index <= '0;
      slot_data <= '0;
      sprite_count <= '0;
      overflow <= 1'b0;
    end else begin
      slot_valid <= store_hit;
      eval_v <= reading;
      if (state == IDLE && start) begin
        rd_cnt <= '0;
        line_q <= line;
        tall_q <= tall_sprites;
        sprite_count <= '0;
        overflow <= 1'b0;
      end else begin
        if (reading) rd_cnt <= rd_cnt + CW'(1);
        if (store_hit) begin
          slot_index <= sprite_count[2:0];
          slot_data <= entry;
          sprite_count <= sprite_count + 4'd1;
        end
        if (over_hit) overflow <= 1'b1;
      end
    end
endmodule

// File: tb/tb_oam_sprite_evaluator.sv
// tb_oam_sprite_evaluator: randomized scoreboard bench against a scanline hit reference model
module tb_oam_sprite_evaluator;
  import oam_pkg::*;
  logic clk = 0, reset = 1, start = 0, tall_sprites = 0;
  logic [7:0] line = 0;
  logic [5:0] oam_read_addr;
  logic [31:0] oam_read_data = 0, slot_data;
  logic slot_valid, busy, done, overflow;
  logic [2:0] slot_index;
  logic [3:0] sprite_count;
  typedef struct {int slot; logic [31:0] data;} exp_t;
  exp_t exp_q[$];
  logic [31:0] oam [NUM_ENTRIES];
  int checks = 0, fails = 0, cyc = 0, done_cyc = 0, last_rd = 0, exp_cnt = 0;
  bit exp_ovf = 0, active = 0;

  oam_sprite_evaluator dut (
    .clk(clk), .reset(reset), .start(start), .line(line), .tall_sprites(tall_sprites),
    .oam_read_addr(oam_read_addr), .oam_read_data(oam_read_data), .slot_valid(slot_valid),
    .slot_index(slot_index), .slot_data(slot_data), .busy(busy), .done(done),
    .sprite_count(sprite_count), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) oam_read_data <= oam[oam_read_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (active) begin
      if (cyc >= 1 && cyc <= last_rd) check("read_addr", 32'(oam_read_addr), 32'(cyc - 1));
      check("busy", 32'(busy), 32'(cyc >= 1 && cyc < done_cyc));
      if (slot_valid) begin
        if (exp_q.size() == 0) check("unexpected_slot", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("slot_index", 32'(slot_index), 32'(e.slot));
          check("slot_data", slot_data, e.data);
        end
      end
      if (done) begin
        check("done_cycle", 32'(cyc), 32'(done_cyc));
        check("sprite_count", 32'(sprite_count), 32'(exp_cnt));
        check("overflow", 32'(overflow), 32'(exp_ovf));
        check("slots_missing", 32'(exp_q.size()), 0);
        check("done_addr", 32'(oam_read_addr), 0);
        active = 0;
      end else if (cyc > done_cyc + 4) begin
        check("done_timeout", 0, 1);
        active = 0;
      end
      cyc++;
    end else begin
      if (slot_valid) check("stray_slot_valid", 32'(slot_valid), 0);
      if (done) check("stray_done", 32'(done), 0);
    end
  end

  task automatic fill(input logic [7:0] y);
    for (int k = 0; k < NUM_ENTRIES; k++) oam[k] = {24'($urandom), y};
  endtask

  task automatic set_y(input int k, input logic [7:0] y);
    oam[k][7:0] = y;
  endtask

  task automatic model(input logic [7:0] ln, input bit tl);
    int cnt = 0, ovf_k = 0;
    bit ovf = 0;
    exp_q.delete();
    for (int k = 0; k < NUM_ENTRIES; k++) begin
      int y = int'(oam[k][7:0]);
      if (!ovf && int'(ln) >= y && int'(ln) - y < (tl ? 16 : 8)) begin
        if (cnt < MAX_SPRITES) begin
          exp_q.push_back('{cnt, oam[k]});
          cnt++;
        end else begin
          ovf = 1;
          ovf_k = k;
        end
      end
    end
    exp_cnt = cnt;
    exp_ovf = ovf;
    done_cyc = ovf ? ovf_k + 3 : NUM_ENTRIES + 2;
    last_rd = !ovf ? NUM_ENTRIES : (ovf_k + 2 < NUM_ENTRIES ? ovf_k + 2 : NUM_ENTRIES);
  endtask

  task automatic issue(input logic [7:0] ln, input bit tl);
    @(posedge clk);
    #1 line = ln; tall_sprites = tl; start = 1; cyc = 0; active = 1;
    @(posedge clk);
    #1 start = 0; line = 8'($urandom); tall_sprites = 1'($urandom);
  endtask

  task automatic run_scan(input logic [7:0] ln, input bit tl, input int pulse_at);
    model(ln, tl);
    issue(ln, tl);
    if (pulse_at > 1) begin
      repeat (pulse_at - 1) @(posedge clk);
      #1 start = 1; line = 8'($urandom); tall_sprites = 1'($urandom);
      @(posedge clk);
      #1 start = 0;
    end
    for (int i = 0; i < 200 && active; i++) @(posedge clk);
    if (active) begin
      check("scan_hang", 0, 1);
      active = 0;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_slot_valid"}, 32'(slot_valid), 0);
    check({tag, "_slot_index"}, 32'(slot_index), 0);
    check({tag, "_slot_data"}, slot_data, 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_count"}, 32'(sprite_count), 0);
    check({tag, "_overflow"}, 32'(overflow), 0);
    check({tag, "_addr"}, 32'(oam_read_addr), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ln;
    fill(8'hFF);
    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    reset = 0;
    run_scan(8'd10, 0, 0);
    fill(8'hFF);
    set_y(3, 8'd5); set_y(17, 8'd5); set_y(40, 8'd5);
    run_scan(8'd12, 0, 0);
    run_scan(8'd12, 1, 0);
    fill(8'hFF);
    for (int k = 0; k < 10; k++) set_y(k, 8'd20);
    run_scan(8'd20, 0, 0);
    fill(8'hFF);
    set_y(5, 8'hF8);
    run_scan(8'h02, 0, 0);
    run_scan(8'h02, 1, 0);
    fill(8'hFF);
    set_y(9, 8'd100); set_y(63, 8'd100);
    run_scan(8'd107, 0, 0);
    run_scan(8'd108, 0, 0);
    run_scan(8'd108, 1, 0);
    fill(8'hFF);
    for (int k = 0; k < 6; k++) set_y(k * 11, 8'd50);
    run_scan(8'd52, 0, 20);
    model(8'd52, 0);
    issue(8'd52, 0);
    repeat (29) @(posedge clk);
    #1 active = 0; reset = 1;
    #1 check_zero("abort");
    @(posedge clk);
    #1 reset = 0;
    exp_q.delete();
    repeat (5) @(posedge clk);
    run_scan(8'd55, 1, 0);
    for (int r = 0; r < 8; r++) begin
      ln = 8'($urandom_range(20, 235));
      for (int k = 0; k < NUM_ENTRIES; k++)
        oam[k] = {24'($urandom), ($urandom_range(0, 3) == 0) ? 8'(int'(ln) - int'($urandom_range(0, 17))) : 8'($urandom)};
      run_scan(ln, 1'($urandom), (r % 3 == 0) ? int'($urandom_range(2, 40)) : 0);
    end
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
